// File: rtl/branch_predict_ctrl_pkg.sv
// Shared definitions for the branch predictor / redirect sequencer: PC-source
// codes, redirect-target selects, counter reset value and FSM states.
package branch_pkg;

   localparam logic [1:0] PCSRC_SEQ  = 2'b00;
   localparam logic [1:0] PCSRC_TGT  = 2'b01;
   localparam logic [1:0] PCSRC_JALR = 2'b10;

   localparam logic [1:0] SEL_RECOVER = 2'b00;
   localparam logic [1:0] SEL_PRED    = 2'b01;
   localparam logic [1:0] SEL_EXEC    = 2'b10;
   localparam logic [1:0] SEL_JALR    = 2'b11;

   localparam logic [1:0] CNT_RESET = 2'b01;

   typedef enum logic {
      RUN     = 1'b0,
      RECOVER = 1'b1
   } state_e;

   typedef struct packed {
      logic       redirect;
      logic [1:0] sel;
      logic       flushD;
      logic       flushE;
   } redirect_t;

   localparam redirect_t NO_REDIRECT = '{redirect: 1'b0, sel: SEL_RECOVER, flushD: 1'b0, flushE: 1'b0};

endpackage

// File: rtl/branch_predict_ctrl_if.sv
// Decode/Execute-side signal bundle between the pipeline datapath (master)
// and the branch predictor controller (slave).
interface branch_predict_ctrl_if #(
   parameter int XLEN = 32
);

   logic            stall_d;
   logic            is_branch_d;
   logic [XLEN-1:0] pc_d;
   logic            pred_taken_d;

   logic            branch_e;
   logic            pred_taken_e;
   logic [XLEN-1:0] pc_e;
   logic [1:0]      pc_src_e;

   logic            redirect;
   logic [1:0]      redirect_sel;
   logic            flush_d;
   logic            flush_e;

   modport master (
      output stall_d, is_branch_d, pc_d, branch_e, pred_taken_e, pc_e, pc_src_e,
      input  pred_taken_d, redirect, redirect_sel, flush_d, flush_e
   );

   modport slave (
      input  stall_d, is_branch_d, pc_d, branch_e, pred_taken_e, pc_e, pc_src_e,
      output pred_taken_d, redirect, redirect_sel, flush_d, flush_e
   );

endinterface

// File: rtl/branch_predict_ctrl_sat.sv
// Next-state logic of a 2-bit saturating up/down counter.
module sat_counter2 (
   input  logic [1:0] cnt_i,
   input  logic       inc_i,
   output logic [1:0] cnt_o
);

   always_comb begin
      cnt_o = cnt_i;
      if (inc_i) begin
         if (cnt_i != 2'b11) cnt_o = cnt_i + 2'b01;
      end else begin
         if (cnt_i != 2'b00) cnt_o = cnt_i - 2'b01;
      end
   end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Bimodal branch predictor and PC-redirect/flush sequencer for the 5-stage pipe.
// Optional performance counters are built when BRANCH_PERF_EN is defined.
module branch_predict_ctrl
   import branch_pkg::*;
#(
   parameter int IDX_W = 4,
   parameter int XLEN  = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   branch_predict_ctrl_if.slave bp
`ifdef BRANCH_PERF_EN
   ,
   output logic [31:0]          perf_branches,
   output logic [31:0]          perf_mispredicts
`endif
);

   localparam int ENTRIES = 2 ** IDX_W;

   logic [1:0]       counters_q [ENTRIES];
   state_e           state_q, state_d;

   logic [XLEN-1:0]  pcD, pcE;
   logic [IDX_W-1:0] idxD, idxE;
   logic             predD;
   logic             mispredictTaken, mispredictNt;
   logic             jumpTgt, jumpJalr;
   logic             eRedirect, dRedirect;
   logic             trainEn, trainInc;
   logic [1:0]       trainNext;
   redirect_t        resp;
   logic             unusedPcBits;

   assign pcD  = bp.pc_d;
   assign pcE  = bp.pc_e;
   assign idxD = pcD[IDX_W+1:2];
   assign idxE = pcE[IDX_W+1:2];
   assign unusedPcBits = ^{pcD[XLEN-1:IDX_W+2], pcD[1:0], pcE[XLEN-1:IDX_W+2], pcE[1:0]};

   assign predD = bp.is_branch_d & counters_q[idxD][1];

   assign mispredictTaken = bp.branch_e & (bp.pc_src_e == PCSRC_TGT) & ~bp.pred_taken_e;
   assign mispredictNt    = bp.branch_e & (bp.pc_src_e == PCSRC_SEQ) &  bp.pred_taken_e;
   assign jumpTgt         = ~bp.branch_e & (bp.pc_src_e == PCSRC_TGT);
   assign jumpJalr        = ~bp.branch_e & (bp.pc_src_e == PCSRC_JALR);
   assign eRedirect       = mispredictTaken | mispredictNt | jumpTgt | jumpJalr;

   // The RECOVER cycle holds the flushed bubble, so neither redirect nor train from it.
   assign dRedirect = ~eRedirect & (state_q == RUN) & predD & ~bp.stall_d;
   assign trainEn   = bp.branch_e & (state_q == RUN);
   assign trainInc  = (bp.pc_src_e == PCSRC_TGT);

   sat_counter2 u_train_cnt (
      .cnt_i (counters_q[idxE]),
      .inc_i (trainInc),
      .cnt_o (trainNext)
   );

   always_comb begin
      resp = NO_REDIRECT;
      if (!rst_n) begin
         resp = NO_REDIRECT;
      end else if (mispredictTaken || jumpTgt) begin
         resp = '{redirect: 1'b1, sel: SEL_EXEC, flushD: 1'b1, flushE: 1'b1};
      end else if (mispredictNt) begin
         resp = '{redirect: 1'b1, sel: SEL_RECOVER, flushD: 1'b1, flushE: 1'b1};
      end else if (jumpJalr) begin
         resp = '{redirect: 1'b1, sel: SEL_JALR, flushD: 1'b1, flushE: 1'b1};
      end else if (dRedirect) begin
         resp = '{redirect: 1'b1, sel: SEL_PRED, flushD: 1'b1, flushE: 1'b0};
      end
   end

   assign bp.pred_taken_d = rst_n & predD;
   assign bp.redirect     = resp.redirect;
   assign bp.redirect_sel = resp.sel;
   assign bp.flush_d      = resp.flushD;
   assign bp.flush_e      = resp.flushE;

   always_comb begin
      state_d = RUN;
      if (eRedirect) state_d = RECOVER;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) counters_q[i] <= CNT_RESET;
         state_q <= RUN;
      end else begin
         state_q <= state_d;
         if (trainEn) counters_q[idxE] <= trainNext;
      end
   end

`ifdef BRANCH_PERF_EN
   logic [31:0] perf_branches_q, perf_mispredicts_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_branches_q    <= '0;
         perf_mispredicts_q <= '0;
      end else begin
         if (trainEn) perf_branches_q <= perf_branches_q + 32'd1;
         if (mispredictTaken || mispredictNt) perf_mispredicts_q <= perf_mispredicts_q + 32'd1;
      end
   end

   assign perf_branches    = perf_branches_q;
   assign perf_mispredicts = perf_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: directed scenarios followed by
// random traffic, all compared against a behavioural predictor model.
module tb_branch_predict_ctrl;
   import branch_pkg::*;

   localparam int IDX_W = 4;
   localparam int NENT  = 16;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   branch_predict_ctrl_if #(.XLEN(32)) bpIf ();

`ifdef BRANCH_PERF_EN
   logic [31:0] perfBranches, perfMispredicts;
`endif

   branch_predict_ctrl #(.IDX_W(IDX_W), .XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bp    (bpIf)
`ifdef BRANCH_PERF_EN
      ,
      .perf_branches    (perfBranches),
      .perf_mispredicts (perfMispredicts)
`endif
   );

   // Behavioural model: counter strength per index, one-cycle recovery flag, perf tallies.
   int          modelCnt [NENT];
   bit          modelRecover;
   int unsigned modelBranches, modelMispredicts;
   int          errors, checks;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic int modelPred(input logic [31:0] pc);
      logic [31:0] p;
      p = pc >> 2;
      return (modelCnt[p % NENT] >= 2) ? 1 : 0;
   endfunction

   task automatic applyStimulus(input bit rstN, input bit stall, input bit isBr, input logic [31:0] pcD,
                                input bit brE, input bit predE, input logic [31:0] pcE, input logic [1:0] src);
      int  expPred, expRed, expSel, expFd, expFe;
      bit  misT, misN, eRed;
      int  iE;
      @(negedge clk);
      rst_n             = rstN;
      bpIf.stall_d      = stall;
      bpIf.is_branch_d  = isBr;
      bpIf.pc_d         = pcD;
      bpIf.branch_e     = brE;
      bpIf.pred_taken_e = predE;
      bpIf.pc_e         = pcE;
      bpIf.pc_src_e     = src;
      #2;
      iE   = int'((pcE >> 2) % NENT);
      misT = brE && src == 2'd1 && !predE;
      misN = brE && src == 2'd0 && predE;
      eRed = misT || misN || (!brE && (src == 2'd1 || src == 2'd2));
      expPred = (rstN && isBr) ? modelPred(pcD) : 0;
      {expRed, expSel, expFd, expFe} = {32'd0, 32'd0, 32'd0, 32'd0};
      if (!rstN) begin
         expRed = 0;
      end else if (eRed) begin
         expRed = 1; expFd = 1; expFe = 1;
         if (misN)           expSel = 0;
         else if (src == 2)  expSel = 3;
         else                expSel = 2;
      end else if (!modelRecover && expPred == 1 && !stall) begin
         expRed = 1; expSel = 1; expFd = 1; expFe = 0;
      end
      checkOutput("pred_taken_d", 32'(bpIf.pred_taken_d), expPred);
      checkOutput("redirect",     32'(bpIf.redirect),     expRed);
      checkOutput("flush_d",      32'(bpIf.flush_d),      expFd);
      checkOutput("flush_e",      32'(bpIf.flush_e),      expFe);
      if (expRed == 1) checkOutput("redirect_sel", 32'(bpIf.redirect_sel), expSel);
`ifdef BRANCH_PERF_EN
      if (rstN) begin
         checkOutput("perf_branches",    perfBranches,    modelBranches);
         checkOutput("perf_mispredicts", perfMispredicts, modelMispredicts);
      end
`endif
      @(posedge clk);
      if (!rstN) begin
         foreach (modelCnt[i]) modelCnt[i] = 1;
         modelRecover     = 0;
         modelBranches    = 0;
         modelMispredicts = 0;
      end else begin
         if (brE && !modelRecover) begin
            modelBranches++;
            if (src == 2'd1) modelCnt[iE] = (modelCnt[iE] == 3) ? 3 : modelCnt[iE] + 1;
            else             modelCnt[iE] = (modelCnt[iE] == 0) ? 0 : modelCnt[iE] - 1;
         end
         if (misT || misN) modelMispredicts++;
         modelRecover = eRed;
      end
   endtask

   task automatic idle(input logic [31:0] pcD, input bit isBr);
      applyStimulus(1, 0, isBr, pcD, 0, 0, 32'h0, 2'd0);
   endtask

   initial begin
      logic [31:0] pcD, pcE;
      bit          brE, predE, isBr, stall, rstN;
      logic [1:0]  src;
      errors = 0;
      checks = 0;
      modelRecover = 0;
      modelBranches = 0;
      modelMispredicts = 0;
      foreach (modelCnt[i]) modelCnt[i] = 1;
      rst_n = 1'b0;
      bpIf.stall_d = 0; bpIf.is_branch_d = 0; bpIf.pc_d = 0;
      bpIf.branch_e = 0; bpIf.pred_taken_e = 0; bpIf.pc_e = 0; bpIf.pc_src_e = 0;

      // Reset held while a mispredict is presented: outputs must stay quiet.
      applyStimulus(0, 0, 1, 32'h100, 1, 0, 32'h100, 2'd1);
      applyStimulus(0, 0, 1, 32'h100, 1, 0, 32'h100, 2'd1);

      idle(32'h100, 1);
      applyStimulus(1, 0, 0, 32'h0, 1, 0, 32'h100, 2'd1);
      idle(32'h100, 1);
      idle(32'h100, 1);

      applyStimulus(1, 0, 0, 32'h0, 1, 1, 32'h100, 2'd1);
      applyStimulus(1, 0, 0, 32'h0, 1, 1, 32'h100, 2'd0);
      idle(32'h100, 1);

      // 0x200 aliases 0x100; the jump must not train the shared counter.
      applyStimulus(1, 0, 1, 32'h100, 0, 0, 32'h200, 2'd2);
      idle(32'h100, 1);
      idle(32'h200, 1);

      for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 32'h100, 0, 0, 32'h0, 2'd0);
      idle(32'h100, 1);

      // Same-index lookup and training in one cycle sees the old counter.
      applyStimulus(1, 0, 1, 32'h100, 1, 1, 32'h100, 2'd0);
      idle(32'h100, 1);
      idle(32'h100, 1);

      applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0, 2'd0);
      for (int i = 0; i < 8; i++) begin
         predE = bit'(modelPred(32'h44));
         applyStimulus(1, 0, 0, 32'h0, 1, predE, 32'h44, 2'd1);
         if (!predE) idle(32'h0, 0);
      end
      idle(32'h44, 1);
      applyStimulus(1, 0, 1, 32'h44, 1, 1, 32'h44, 2'd0);
      idle(32'h44, 1);
      idle(32'h44, 1);

      for (int n = 0; n < 600; n++) begin
         rstN  = ($urandom_range(0, 59) != 0);
         stall = ($urandom_range(0, 3) == 0);
         isBr  = ($urandom_range(0, 2) != 0);
         pcD   = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 5) << 2);
         pcE   = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 5) << 2);
         brE   = ($urandom_range(0, 1) == 1);
         src   = brE ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 2));
         predE = ($urandom_range(0, 3) == 0) ? bit'($urandom_range(0, 1)) : bit'(modelPred(pcE));
         applyStimulus(rstN, stall, isBr, pcD, brE, predE, pcE, src);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
